// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around an external dual-port RAM with a fixed
// 2-cycle read latency; a 4-entry output buffer absorbs the read pipeline.
module ram_fifo_ctrl #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 6,
   parameter int DEPTH = 2**ASIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [DSIZE-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DSIZE-1:0] m_data,
   output logic             ram_wen,
   output logic [ASIZE-1:0] ram_waddr,
   output logic [DSIZE-1:0] ram_wdata,
   output logic [ASIZE-1:0] ram_raddr,
   input  logic [DSIZE-1:0] ram_rdata,
   output logic [ASIZE+1:0] count,
   output logic             empty
);

   localparam logic [ASIZE:0] OCC_FULL = DEPTH[ASIZE:0];

   logic [ASIZE-1:0] wptr_q, wptr_d;
   logic [ASIZE-1:0] rptr_q, rptr_d;
   logic [ASIZE:0]   occ_q, occ_d;
   logic [1:0]       vpipe_q, vpipe_d;
   logic [DSIZE-1:0] obuf_q [4];
   logic [1:0]       ohead_q, ohead_d;
   logic [1:0]       otail_q, otail_d;
   logic [2:0]       ocnt_q, ocnt_d;

   logic       rd_issue;
   logic       push;
   logic       pop;
   logic [2:0] credit_used;

   always_comb begin
      // Words already committed downstream: buffered plus still in the RAM pipeline.
      credit_used = ocnt_q + {2'b00, vpipe_q[0]} + {2'b00, vpipe_q[1]};
      s_ready     = (occ_q != OCC_FULL);
      ram_wen     = s_valid & s_ready;
      rd_issue    = (occ_q != '0) && (credit_used < 3'd4);
      push        = vpipe_q[1];
      m_valid     = (ocnt_q != '0);
      pop         = m_valid & m_ready;

      wptr_d  = ram_wen  ? wptr_q + ASIZE'(1) : wptr_q;
      rptr_d  = rd_issue ? rptr_q + ASIZE'(1) : rptr_q;
      vpipe_d = {vpipe_q[0], rd_issue};

      occ_d = occ_q;
      unique case ({ram_wen, rd_issue})
         2'b10:   occ_d = occ_q + (ASIZE+1)'(1);
         2'b01:   occ_d = occ_q - (ASIZE+1)'(1);
         default: occ_d = occ_q;
      endcase

      ocnt_d  = ocnt_q + {2'b00, push} - {2'b00, pop};
      ohead_d = pop  ? ohead_q + 2'd1 : ohead_q;
      otail_d = push ? otail_q + 2'd1 : otail_q;
   end

   assign ram_waddr = wptr_q;
   assign ram_wdata = s_data;
   assign ram_raddr = rptr_q;
   assign m_data    = obuf_q[ohead_q];
   assign count     = {1'b0, occ_q} + (ASIZE+2)'(credit_used);
   assign empty     = (count == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         occ_q   <= '0;
         vpipe_q <= '0;
         ohead_q <= '0;
         otail_q <= '0;
         ocnt_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         occ_q   <= occ_d;
         vpipe_q <= vpipe_d;
         ohead_q <= ohead_d;
         otail_q <= otail_d;
         ocnt_q  <= ocnt_d;
      end
   end

   // Storage needs no reset: a flush clears ocnt_q, so any capture at that edge is dead.
   always_ff @(posedge clk) begin
      if (push) obuf_q[otail_q] <= ram_rdata;
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 2-cycle-latency RAM and a
// scoreboard queue of expected output words.
module tb_ram_fifo_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst, clr;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid, m_ready;
   logic [DW-1:0] m_data;
   logic          ram_wen;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic [AW+1:0] count;
   logic          empty;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_stage;

   int            checks = 0;
   int            passed = 0;
   logic [DW-1:0] exp_q [$];

   ram_fifo_ctrl #(.DSIZE(DW), .ASIZE(AW)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   // Address sampled at the first edge, data registered at the second.
   always @(posedge clk) begin
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      rd_stage  <= mem[ram_raddr];
      ram_rdata <= rd_stage;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      tick();
      tick();
      checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b expected 0", m_valid); else passed++;
      checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", s_ready); else passed++;
      checks++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
      checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
      checks++; if (ram_wen !== 1'b0) $display("FAIL reset_ram_wen: got %b expected 0", ram_wen); else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_first_word();
      logic [DW-1:0] e;
      m_ready = 1'b1; s_valid = 1'b1; s_data = 32'hA0;
      #1;
      checks++;
      if (ram_wen !== 1'b1 || ram_waddr !== 4'd0)
         $display("FAIL first_write: got wen=%b waddr=%0d expected wen=1 waddr=0", ram_wen, ram_waddr);
      else passed++;
      exp_q.push_back(32'hA0);
      tick();
      s_valid = 1'b0;
      #1;
      checks++; if (ram_raddr !== 4'd0) $display("FAIL first_raddr: got %0d expected 0", ram_raddr); else passed++;
      checks++; if (count !== 6'd1) $display("FAIL first_count: got %0d expected 1", count); else passed++;
      for (int c = 2; c <= 6; c++) begin
         tick();
         if (c == 2) begin
            checks++; if (ram_raddr !== 4'd1) $display("FAIL first_issued: got raddr %0d expected 1", ram_raddr); else passed++;
         end
         checks++;
         if (m_valid !== (c == 4)) $display("FAIL first_m_valid_c%0d: got %b expected %b", c, m_valid, (c == 4));
         else passed++;
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL first_data: got %h expected nothing", m_data);
            else begin
               e = exp_q.pop_front();
               if (m_data !== e) $display("FAIL first_data: got %h expected %h", m_data, e); else passed++;
            end
         end
         if (c == 5) begin
            checks++; if (count !== '0 || empty !== 1'b1) $display("FAIL first_drained: got count=%0d empty=%b expected 0/1", count, empty); else passed++;
         end
      end
   endtask

   task automatic test_fill_drain();
      logic [DW-1:0] e;
      int n = 0, cyc = 0, first = -1, last = -1;
      m_ready = 1'b0;
      while (n < 20 && cyc < 40) begin
         s_valid = 1'b1; s_data = DW'(n);
         #1;
         if (s_ready) begin exp_q.push_back(DW'(n)); n++; end
         tick();
         cyc++;
      end
      checks++; if (cyc !== 20) $display("FAIL fill_b2b: got %0d cycles for %0d accepts expected 20", cyc, n); else passed++;
      s_data = 32'hDEAD;
      #1;
      checks++; if (s_ready !== 1'b0) $display("FAIL fill_s_ready: got %b expected 0", s_ready); else passed++;
      checks++; if (count !== 6'd20) $display("FAIL fill_count: got %0d expected 20", count); else passed++;
      s_valid = 1'b0;
      repeat (3) tick();
      checks++; if (s_ready !== 1'b0 || count !== 6'd20) $display("FAIL fill_hold: got s_ready=%b count=%0d expected 0/20", s_ready, count); else passed++;
      m_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         #1;
         if (m_valid) begin
            checks++;
            e = exp_q.pop_front();
            if (m_data !== e) $display("FAIL drain_data: got %h expected %h", m_data, e); else passed++;
            if (first < 0) first = c;
            last = c;
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size()); else passed++;
      checks++; if (first != 0 || last - first != 19) $display("FAIL drain_gapless: got first=%0d last=%0d expected 0/19", first, last); else passed++;
      checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else passed++;
   endtask

   task automatic test_stream();
      logic [DW-1:0] e;
      int sent = 0, recv = 0, first = -1, last = -1;
      m_ready = 1'b1;
      for (int c = 0; c < 300 && recv < 100; c++) begin
         s_valid = (sent < 100); s_data = DW'(sent);
         #1;
         if (s_valid && s_ready) begin exp_q.push_back(DW'(sent)); sent++; end
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL stream_data: got %h expected nothing", m_data);
            else begin
               e = exp_q.pop_front();
               if (m_data !== e) $display("FAIL stream_data: got %h expected %h", m_data, e); else passed++;
            end
            recv++;
            if (first < 0) first = c;
            last = c;
         end
         tick();
      end
      s_valid = 1'b0;
      checks++; if (recv != 100) $display("FAIL stream_count: got %0d expected 100", recv); else passed++;
      checks++; if (first != 4) $display("FAIL stream_latency: got %0d expected 4", first); else passed++;
      checks++; if (last - first != 99) $display("FAIL stream_bubbles: got span %0d expected 99", last - first); else passed++;
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] e, prev_data;
      logic prev_stall = 1'b0;
      int sent = 0, recv = 0;
      for (int c = 0; c < 400 && recv < 40; c++) begin
         s_valid = (sent < 40); s_data = 32'h1000 + DW'(sent);
         m_ready = (c % 2 == 0);
         #1;
         if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data)
               $display("FAIL stall_hold: got valid=%b data=%h expected 1/%h", m_valid, m_data, prev_data);
            else passed++;
         end
         if (s_valid && s_ready) begin exp_q.push_back(32'h1000 + DW'(sent)); sent++; end
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL bp_data: got %h expected nothing", m_data);
            else begin
               e = exp_q.pop_front();
               if (m_data !== e) $display("FAIL bp_data: got %h expected %h", m_data, e); else passed++;
            end
            recv++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         tick();
      end
      s_valid = 1'b0; m_ready = 1'b0;
      #1;
      checks++; if (recv != 40) $display("FAIL bp_count: got %0d expected 40", recv); else passed++;
      checks++; if (empty !== 1'b1 || exp_q.size() != 0) $display("FAIL bp_empty: got empty=%b left=%0d expected 1/0", empty, exp_q.size()); else passed++;
   endtask

   task automatic test_clr();
      logic [DW-1:0] e;
      int n = 0;
      m_ready = 1'b0;
      for (int c = 0; c < 40 && n < 12; c++) begin
         s_valid = 1'b1; s_data = 32'h2000 + DW'(n);
         #1;
         if (s_ready) begin exp_q.push_back(32'h2000 + DW'(n)); n++; end
         tick();
      end
      s_valid = 1'b0;
      repeat (6) tick();
      // Two pops open credits; issues in the 2nd and 3rd cycles leave both pipe stages busy.
      for (int c = 0; c < 3; c++) begin
         m_ready = (c < 2);
         #1;
         if (m_valid && m_ready) begin
            checks++;
            e = exp_q.pop_front();
            if (m_data !== e) $display("FAIL clr_pre_data: got %h expected %h", m_data, e); else passed++;
         end
         tick();
      end
      checks++; if (count !== 6'd10) $display("FAIL clr_held: got %0d expected 10", count); else passed++;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_q.delete();
      checks++; if (count !== '0) $display("FAIL clr_count: got %0d expected 0", count); else passed++;
      checks++; if (m_valid !== 1'b0) $display("FAIL clr_m_valid: got %b expected 0", m_valid); else passed++;
      checks++; if (s_ready !== 1'b1 || empty !== 1'b1) $display("FAIL clr_status: got s_ready=%b empty=%b expected 1/1", s_ready, empty); else passed++;
      m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++; if (m_valid !== 1'b0) $display("FAIL clr_discard_c%0d: got %b expected 0", c, m_valid); else passed++;
      end
      s_valid = 1'b1; s_data = 32'h55;
      #1;
      checks++; if (ram_wen !== 1'b1) $display("FAIL clr_rewrite: got %b expected 1", ram_wen); else passed++;
      tick();
      s_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         checks++;
         if (m_valid !== (c == 4)) $display("FAIL clr_new_valid_c%0d: got %b expected %b", c, m_valid, (c == 4));
         else passed++;
         if (c == 4) begin
            checks++; if (m_data !== 32'h55) $display("FAIL clr_new_data: got %h expected 00000055", m_data); else passed++;
         end
         tick();
      end
   endtask

   task automatic test_full_overwrite();
      logic [DW-1:0] e;
      int n = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0; m_ready = 1'b0;
      for (int c = 0; c < 40 && n < 20; c++) begin
         s_valid = 1'b1; s_data = 32'h600 + DW'(n);
         #1;
         if (s_ready) begin exp_q.push_back(32'h600 + DW'(n)); n++; end
         tick();
      end
      s_valid = 1'b0;
      repeat (4) tick();
      checks++; if (s_ready !== 1'b0 || count !== 6'd20) $display("FAIL full_state: got s_ready=%b count=%0d expected 0/20", s_ready, count); else passed++;
      m_ready = 1'b1;
      #1;
      checks++;
      if (!m_valid) $display("FAIL full_pop: got m_valid 0 expected 1");
      else begin
         e = exp_q.pop_front();
         if (m_data !== e) $display("FAIL full_pop: got %h expected %h", m_data, e); else passed++;
      end
      tick();
      m_ready = 1'b0;
      #1;
      checks++; if (s_ready !== 1'b0) $display("FAIL full_issue_cycle: got s_ready %b expected 0", s_ready); else passed++;
      checks++; if (ram_raddr !== 4'd4) $display("FAIL full_issue_addr: got %0d expected 4", ram_raddr); else passed++;
      tick();
      s_valid = 1'b1; s_data = 32'hBEEF;
      #1;
      checks++; if (s_ready !== 1'b1) $display("FAIL full_reopen: got s_ready %b expected 1", s_ready); else passed++;
      checks++;
      if (ram_wen !== 1'b1 || ram_waddr !== 4'd4)
         $display("FAIL full_same_addr: got wen=%b waddr=%0d expected 1/4", ram_wen, ram_waddr);
      else passed++;
      if (s_ready) exp_q.push_back(32'hBEEF);
      tick();
      s_valid = 1'b0; m_ready = 1'b1;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         #1;
         if (m_valid) begin
            checks++;
            e = exp_q.pop_front();
            if (m_data !== e) $display("FAIL full_drain_data: got %h expected %h", m_data, e); else passed++;
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) $display("FAIL full_drain_timeout: got %0d left expected 0", exp_q.size()); else passed++;
      #1;
      checks++; if (empty !== 1'b1 || m_valid !== 1'b0) $display("FAIL full_final: got empty=%b m_valid=%b expected 1/0", empty, m_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_first_word();
      test_fill_drain();
      test_stream();
      test_backpressure();
      test_clr();
      test_full_overwrite();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Pointer/flow controller that turns an external `ram_dp` instance into a streaming FIFO.
- Both sides use valid/ready handshakes; the write side is upstream, the read side downstream.
- The block drives the RAM write and read ports and tracks the RAM's fixed 2-cycle registered read latency.
- A 4-entry output buffer holds returned read data, so the block sustains 1 word/cycle under backpressure.

Parameters:
- DSIZE, 32, data width; must match the RAM.
- ASIZE, 6, RAM address width; must match the RAM.
- DEPTH, 2**ASIZE, RAM entries; fixed at 2**ASIZE, other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as rst on controller state.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream may transfer.
- s_data  in  DSIZE  upstream word.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DSIZE  downstream word.
- ram_wen  out  1  RAM write enable.
- ram_waddr  out  ASIZE  RAM write address.
- ram_wdata  out  DSIZE  RAM write data.
- ram_raddr  out  ASIZE  RAM read address.
- ram_rdata  in  DSIZE  RAM read data; corresponds to the ram_raddr value presented 2 cycles earlier.
- count  out  ASIZE+2  total words held (RAM + in flight + output buffer).
- empty  out  1  count==0.

Behaviour:
- State:
  - wptr, rptr: ASIZE bits, wrap modulo DEPTH.
  - ram_occ: 0..DEPTH, words written but not yet read-issued.
  - vpipe[1:0]: in-flight read valid shift register.
  - obuf: 4-entry FIFO with obuf_cnt.
- Reset/clr: wptr=rptr=0, ram_occ=0, vpipe=0, obuf emptied. Results: m_valid=0, s_ready=1, count=0, empty=1, ram_wen=0. In-flight reads are discarded; their returned data is never captured. RAM contents are untouched.
- Write side (combinational from registered state):
  - s_ready = (ram_occ != DEPTH).
  - ram_wen = s_valid & s_ready; ram_waddr = wptr; ram_wdata = s_data.
  - On ram_wen, wptr increments at the clock edge.
- Read issue:
  - rd_issue = (ram_occ != 0) & (obuf_cnt + vpipe[0] + vpipe[1] < 4).
  - ram_occ is registered, so a word written in cycle n is issuable no earlier than cycle n+1. This avoids read-during-write on the same address.
  - ram_raddr = rptr at all times; rptr increments on rd_issue.
- ram_occ update: +1 on write only, -1 on issue only, unchanged when both occur in the same cycle.
- Latency pipeline:
  - vpipe[0] <= rd_issue; vpipe[1] <= vpipe[0].
  - When vpipe[1]=1, ram_rdata is pushed into obuf at that edge.
  - The credit check guarantees obuf never overflows. A capture into obuf and a pop from obuf may occur in the same cycle.
- Output:
  - m_valid = (obuf_cnt != 0); m_data = obuf head.
  - A pop occurs on m_valid & m_ready.
  - m_data is held stable while m_valid & !m_ready.
- Timing:
  - First-word latency: write accepted in cycle 0 → issue in cycle 1 → ram_rdata valid in cycle 3 → m_valid=1 in cycle 4.
  - Throughput: 1 word/cycle sustained with s_valid=m_ready=1.
- Capacity and status:
  - Capacity is DEPTH words in RAM plus up to 4 downstream.
  - s_ready depends only on ram_occ; it deasserts when ram_occ==DEPTH.
  - count = ram_occ + vpipe[0] + vpipe[1] + obuf_cnt; registered-state function, max DEPTH+4.
- Ordering: strict FIFO order, no loss or duplication, across wrap of wptr/rptr.

Test Plan:
1. Reset, then with ASIZE=4, write 0xA0 in cycle 0 with m_ready=1 → ram_raddr=0 issued in cycle 1; m_valid=1 with m_data=0xA0 in cycle 4, for exactly 1 cycle; count returns to 0 and empty=1.
2. m_ready=0; write 0..19 back-to-back → s_ready drops after 20 accepts (16 RAM + 4 obuf), count=20; then m_ready=1 → 0..19 out in order at 1/cycle, with no gap after the first.
3. Streaming with s_valid=m_ready=1 for 100 words (values 0..99), wrapping pointers 6 times → output is 0..99 in order, with no bubbles after the initial 4-cycle latency.
4. m_ready toggles 1/0 each cycle for 40 words → m_data is stable whenever stalled; there is no obuf overflow and no data loss; the order is preserved.
5. Assert clr in the cycle vpipe=2'b11 while 10 words are held → next cycle count=0, m_valid=0, s_ready=1. The two returning RAM words are not output. A subsequent write 0x55 emerges 4 cycles later.
6. Full RAM (ram_occ=16) with m_ready=0, then pop 1 → issue frees a slot; s_ready=1 the cycle after the issue. A write in that cycle to the same address as the just-issued read does not corrupt the issued word.
